config_frame_loader: RTL and testbench



---
 rtl/config_loader_pkg.sv | 28 ++
 rtl/frame_strobe_decoder.sv | 31 +++
 rtl/config_frame_loader.sv | 167 ++++++++++++++++
 tb/tb_config_frame_loader.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/config_loader_pkg.sv
// Shared definitions for the configuration frame loader: FSM states,
// header command codes and field positions, default stream sync pattern.
package config_loader_pkg;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_HEADER = 2'd1,
        ST_DATA   = 2'd2,
        ST_STROBE = 2'd3
    } loader_state_e;

    localparam logic [7:0] CMD_DESYNC      = 8'h00;
    localparam logic [7:0] CMD_WRITE_FRAME = 8'h01;

    // Header word layout: [31:24] cmd, [23:16] col, [15:8] frame, [7:0] unused.
    localparam int HDR_FIELD_W   = 8;
    localparam int HDR_CMD_LSB   = 24;
    localparam int HDR_COL_LSB   = 16;
    localparam int HDR_FRAME_LSB = 8;

    localparam logic [31:0] DEFAULT_SYNC_WORD = 32'hFAB0_FAB1;

    // Counter/index width that stays legal when a dimension collapses to 1.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/frame_strobe_decoder.sv
// One-hot decode of a (column, frame) address onto the flat FrameStrobe
// vector; purely combinational, the parent registers the result.
module frame_strobe_decoder
    import config_loader_pkg::*;
#(
    parameter int NumColumns      = 16,
    parameter int MaxFramesPerCol = 20,
    localparam int ColW    = clog2_min1(NumColumns),
    localparam int FrameW  = clog2_min1(MaxFramesPerCol),
    localparam int NumBits = NumColumns * MaxFramesPerCol,
    localparam int IdxW    = clog2_min1(NumBits)
) (
    input  logic [ColW-1:0]    col,
    input  logic [FrameW-1:0]  frame,
    input  logic               enable,
    output logic [NumBits-1:0] strobe
);

    logic [IdxW-1:0] idx;

    // Callers guarantee col/frame are in range, so idx < NumBits.
    assign idx = IdxW'(col) * IdxW'(MaxFramesPerCol) + IdxW'(frame);

    always_comb begin
        strobe = '0;
        for (int i = 0; i < NumBits; i++) begin
            strobe[i] = enable && (idx == IdxW'(i));
        end
    end

endmodule

// File: rtl/config_frame_loader.sv
// Configuration stream writer: locks on a sync word, decodes frame-write
// headers, assembles NumRows data words and pulses one column frame strobe.
module config_frame_loader
    import config_loader_pkg::*;
#(
    parameter int          NumRows         = 8,
    parameter int          NumColumns      = 16,
    parameter int          MaxFramesPerCol = 20,
    parameter logic [31:0] SyncWord        = DEFAULT_SYNC_WORD
) (
    input  logic                                   CLK,
    input  logic                                   RST,
    input  logic [31:0]                            WriteData,
    input  logic                                   WriteValid,
    output logic                                   WriteReady,
    output logic [NumRows*32-1:0]                  FrameData,
    output logic [NumColumns*MaxFramesPerCol-1:0]  FrameStrobe,
    output logic                                   Locked,
    output logic                                   CfgError
);

    localparam int ColW    = clog2_min1(NumColumns);
    localparam int FrameW  = clog2_min1(MaxFramesPerCol);
    localparam int RowW    = clog2_min1(NumRows);
    localparam int NumBits = NumColumns * MaxFramesPerCol;

    loader_state_e state, next_state;

    logic                  write_ready;
    logic                  locked;
    logic                  cfg_error;
    logic [RowW-1:0]       row_cnt;
    logic [ColW-1:0]       col_q;
    logic [FrameW-1:0]     frame_q;
    logic [NumRows*32-1:0] frame_data;
    logic [NumBits-1:0]    frame_strobe;
    logic [NumBits-1:0]    strobe_dec;

    logic       accept;
    logic [7:0] hdr_cmd;
    logic [7:0] hdr_col;
    logic [7:0] hdr_frame;
    logic       addr_in_range;

    logic set_lock;
    logic clr_lock;
    logic set_err;
    logic load_addr;
    logic data_we;
    logic strobe_en;

    assign accept    = WriteValid && write_ready;
    assign hdr_cmd   = WriteData[HDR_CMD_LSB   +: HDR_FIELD_W];
    assign hdr_col   = WriteData[HDR_COL_LSB   +: HDR_FIELD_W];
    assign hdr_frame = WriteData[HDR_FRAME_LSB +: HDR_FIELD_W];

    // Range check on the full 8-bit fields, before any truncation to ColW/FrameW.
    assign addr_in_range = ({24'd0, hdr_col}   < 32'(NumColumns)) &&
                           ({24'd0, hdr_frame} < 32'(MaxFramesPerCol));

    always_comb begin
        next_state = state;
        set_lock   = 1'b0;
        clr_lock   = 1'b0;
        set_err    = 1'b0;
        load_addr  = 1'b0;
        data_we    = 1'b0;
        strobe_en  = 1'b0;
        unique case (state)
            ST_HUNT: begin
                if (accept && (WriteData == SyncWord)) begin
                    next_state = ST_HEADER;
                    set_lock   = 1'b1;
                end
            end
            ST_HEADER: begin
                if (accept) begin
                    if (hdr_cmd == CMD_WRITE_FRAME) begin
                        if (addr_in_range) begin
                            load_addr  = 1'b1;
                            next_state = ST_DATA;
                        end else begin
                            set_err    = 1'b1;
                            clr_lock   = 1'b1;
                            next_state = ST_HUNT;
                        end
                    end else if (hdr_cmd == CMD_DESYNC) begin
                        clr_lock   = 1'b1;
                        next_state = ST_HUNT;
                    end
                end
            end
            ST_DATA: begin
                if (accept) begin
                    data_we = 1'b1;
                    if (row_cnt == RowW'(NumRows - 1)) begin
                        strobe_en  = 1'b1;
                        next_state = ST_STROBE;
                    end
                end
            end
            ST_STROBE: begin
                next_state = ST_HEADER;
            end
            default: begin
                next_state = ST_HUNT;
            end
        endcase
    end

    frame_strobe_decoder #(
        .NumColumns      (NumColumns),
        .MaxFramesPerCol (MaxFramesPerCol)
    ) u_strobe_dec (
        .col    (col_q),
        .frame  (frame_q),
        .enable (strobe_en),
        .strobe (strobe_dec)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= ST_HUNT;
            write_ready  <= 1'b1;
            locked       <= 1'b0;
            cfg_error    <= 1'b0;
            row_cnt      <= '0;
            col_q        <= '0;
            frame_q      <= '0;
            frame_data   <= '0;
            frame_strobe <= '0;
        end else begin
            state        <= next_state;
            // Ready is registered off next_state so it never depends on WriteValid combinationally.
            write_ready  <= (next_state != ST_STROBE);
            frame_strobe <= strobe_dec;
            if (set_lock) begin
                locked <= 1'b1;
            end else if (clr_lock) begin
                locked <= 1'b0;
            end
            if (set_err) begin
                cfg_error <= 1'b1;
            end
            if (load_addr) begin
                col_q   <= ColW'(hdr_col);
                frame_q <= FrameW'(hdr_frame);
                row_cnt <= '0;
            end
            if (data_we) begin
                for (int r = 0; r < NumRows; r++) begin
                    if (row_cnt == RowW'(r)) begin
                        frame_data[r*32 +: 32] <= WriteData;
                    end
                end
                row_cnt <= row_cnt + RowW'(1);
            end
        end
    end

    assign WriteReady  = write_ready;
    assign Locked      = locked;
    assign CfgError    = cfg_error;
    assign FrameData   = frame_data;
    assign FrameStrobe = frame_strobe;

endmodule

// File: tb/tb_config_frame_loader.sv
// Self-checking bench for config_frame_loader: per-cycle vector table plus
// hand-written sequences for gapped back-to-back frames and reset mid-frame.
module tb_config_frame_loader;

    localparam int NR   = 8;
    localparam int NC   = 16;
    localparam int NF   = 20;
    localparam int NB   = NC * NF;
    localparam logic [31:0] SYNC = 32'hFAB0_FAB1;

    logic              clk;
    logic              rst;
    logic [31:0]       write_data;
    logic              write_valid;
    logic              write_ready;
    logic [NR*32-1:0]  frame_data;
    logic [NB-1:0]     frame_strobe;
    logic              locked;
    logic              cfg_error;

    int n_checks = 0;
    int n_pass   = 0;
    int strobe_log[$];

    config_frame_loader #(
        .NumRows         (NR),
        .NumColumns      (NC),
        .MaxFramesPerCol (NF),
        .SyncWord        (SYNC)
    ) dut (
        .CLK         (clk),
        .RST         (rst),
        .WriteData   (write_data),
        .WriteValid  (write_valid),
        .WriteReady  (write_ready),
        .FrameData   (frame_data),
        .FrameStrobe (frame_strobe),
        .Locked      (locked),
        .CfgError    (cfg_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each non-zero strobe cycle is logged once; -1 marks a non-one-hot vector.
    always @(negedge clk) begin
        if (frame_strobe !== '0) begin
            if ($countones(frame_strobe) != 1) begin
                strobe_log.push_back(-1);
            end else begin
                for (int b = 0; b < NB; b++) begin
                    if (frame_strobe[b]) strobe_log.push_back(b);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic        rst;
        logic        valid;
        logic [31:0] data;
        logic        exp_ready;
        logic        exp_locked;
        logic        exp_err;
        int          exp_strobe;
        logic        exp_fd_zero;
    } vec_t;

    function automatic vec_t mk(logic r, logic v, logic [31:0] d, logic rdy,
                                logic lck, logic err, int stb, logic fd0);
        vec_t x;
        x.rst = r; x.valid = v; x.data = d; x.exp_ready = rdy;
        x.exp_locked = lck; x.exp_err = err; x.exp_strobe = stb; x.exp_fd_zero = fd0;
        return x;
    endfunction

    function automatic logic [NB-1:0] onehot(int idx);
        logic [NB-1:0] v;
        v = '0;
        if (idx >= 0) v[idx] = 1'b1;
        return v;
    endfunction

    task automatic check(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_word(input logic [31:0] d, input int max_gap);
        int   gap;
        logic acc;
        gap = $urandom_range(max_gap, 0);
        repeat (gap) begin
            @(negedge clk);
            write_valid = 1'b0;
        end
        acc = 1'b0;
        for (int t = 0; t < 20 && !acc; t++) begin
            @(negedge clk);
            write_valid = 1'b1;
            write_data  = d;
            acc = write_ready;
            @(posedge clk);
        end
        check("accept_within_budget", NB'(acc), NB'(1'b1));
    endtask

    task automatic check_frame(input string name, input logic [31:0] base, input int special_row);
        for (int r = 0; r < NR; r++) begin
            logic [31:0] exp_row;
            exp_row = (r == special_row) ? SYNC : base + 32'(r);
            check($sformatf("%s_row%0d", name, r), NB'(frame_data[r*32 +: 32]), NB'(exp_row));
        end
    endtask

    vec_t vecs[$];
    int   log_mark;

    initial begin
        rst         = 1'b1;
        write_valid = 1'b0;
        write_data  = '0;

        // ---- Table: lock, frame col 3 frame 5, strobe, range errors, desync ----
        vecs.push_back(mk(1, 0, 32'h0,         1, 0, 0, -1, 1));
        vecs.push_back(mk(0, 1, 32'h1234_5678, 1, 0, 0, -1, 1));
        vecs.push_back(mk(0, 1, 32'hFAB0_FAB0, 1, 0, 0, -1, 1));
        vecs.push_back(mk(0, 1, 32'h0103_0500, 1, 0, 0, -1, 1));
        vecs.push_back(mk(0, 0, SYNC,          1, 0, 0, -1, 1));
        vecs.push_back(mk(0, 1, SYNC,          1, 1, 0, -1, 1));
        vecs.push_back(mk(0, 1, 32'h0203_0500, 1, 1, 0, -1, 1));
        vecs.push_back(mk(0, 1, 32'h0103_0500, 1, 1, 0, -1, 1));
        for (int i = 0; i < 8; i++) begin
            if (i == 4) vecs.push_back(mk(0, 0, SYNC, 1, 1, 0, -1, 0));
            if (i < 7) vecs.push_back(mk(0, 1, 32'h1000_0000 + 32'(i), 1, 1, 0, -1, 0));
            else       vecs.push_back(mk(0, 1, 32'h1000_0007,          0, 1, 0, 65, 0));
        end
        vecs.push_back(mk(0, 1, 32'h0000_0000, 1, 1, 0, -1, 0));
        vecs.push_back(mk(0, 1, 32'h0110_0000, 1, 0, 1, -1, 0));
        vecs.push_back(mk(0, 1, 32'h0103_0500, 1, 0, 1, -1, 0));
        vecs.push_back(mk(0, 1, 32'h1000_0000, 1, 0, 1, -1, 0));
        vecs.push_back(mk(0, 1, SYNC,          1, 1, 1, -1, 0));
        vecs.push_back(mk(0, 1, 32'h0100_1400, 1, 0, 1, -1, 0));
        vecs.push_back(mk(0, 1, SYNC,          1, 1, 1, -1, 0));
        vecs.push_back(mk(0, 1, 32'h0000_0000, 1, 0, 1, -1, 0));
        vecs.push_back(mk(0, 1, 32'h0103_0500, 1, 0, 1, -1, 0));
        vecs.push_back(mk(0, 1, 32'h1000_0001, 1, 0, 1, -1, 0));

        foreach (vecs[k]) begin
            @(negedge clk);
            rst         = vecs[k].rst;
            write_valid = vecs[k].valid;
            write_data  = vecs[k].data;
            @(posedge clk);
            #1;
            check($sformatf("v%0d_ready", k),  NB'(write_ready), NB'(vecs[k].exp_ready));
            check($sformatf("v%0d_locked", k), NB'(locked),      NB'(vecs[k].exp_locked));
            check($sformatf("v%0d_cfgerr", k), NB'(cfg_error),   NB'(vecs[k].exp_err));
            check($sformatf("v%0d_strobe", k), frame_strobe,     onehot(vecs[k].exp_strobe));
            if (vecs[k].exp_fd_zero) check($sformatf("v%0d_fd_zero", k), NB'(frame_data), '0);
        end
        check_frame("frame_c3f5", 32'h1000_0000, -1);
        check("table_strobe_count", NB'(strobe_log.size()), NB'(1));
        check("table_strobe_bit", NB'(strobe_log[0]), NB'(65));

        // ---- Back-to-back frames with random gaps: col 15/frame 19, then col 0/frame 0 ----
        @(negedge clk);
        rst = 1'b1;
        write_valid = 1'b0;
        @(posedge clk);
        #1;
        check("rst_clears_cfgerr", NB'(cfg_error), NB'(1'b0));
        @(negedge clk);
        rst = 1'b0;
        log_mark = strobe_log.size();
        send_word(SYNC, 2);
        send_word(32'h010F_1300, 2);
        for (int i = 0; i < NR; i++) send_word(32'h2000_0000 + 32'(i), 2);
        @(negedge clk);
        write_valid = 1'b0;
        check("b2b_strobe319", frame_strobe, onehot(319));
        check("b2b_ready_low", NB'(write_ready), NB'(1'b0));
        check_frame("frame_c15f19", 32'h2000_0000, -1);
        send_word(32'h0100_0000, 2);
        for (int i = 0; i < NR; i++) send_word((i == 3) ? SYNC : 32'h3000_0000 + 32'(i), 2);
        @(negedge clk);
        write_valid = 1'b0;
        check("b2b_strobe0", frame_strobe, onehot(0));
        check_frame("frame_c0f0", 32'h3000_0000, 3);
        repeat (3) @(negedge clk);
        check("b2b_strobe_count", NB'(strobe_log.size() - log_mark), NB'(2));
        if (strobe_log.size() - log_mark == 2) begin
            check("b2b_first_bit",  NB'(strobe_log[log_mark]),     NB'(319));
            check("b2b_second_bit", NB'(strobe_log[log_mark + 1]), NB'(0));
        end

        // ---- Reset after 4 of 8 data words ----
        send_word(SYNC, 1);
        send_word(32'h0102_0300, 1);
        for (int i = 0; i < 4; i++) send_word(32'h4000_0000 + 32'(i), 1);
        log_mark = strobe_log.size();
        @(negedge clk);
        rst = 1'b1;
        write_valid = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_fd",     NB'(frame_data),  '0);
        check("midrst_strobe", frame_strobe,     '0);
        check("midrst_locked", NB'(locked),      NB'(1'b0));
        check("midrst_err",    NB'(cfg_error),   NB'(1'b0));
        check("midrst_ready",  NB'(write_ready), NB'(1'b1));
        @(negedge clk);
        rst = 1'b0;
        for (int i = 4; i < 8; i++) send_word(32'h4000_0000 + 32'(i), 1);
        send_word(32'h0102_0300, 1);
        for (int i = 0; i < 8; i++) send_word(32'h5000_0000 + 32'(i), 1);
        @(negedge clk);
        write_valid = 1'b0;
        check("postrst_unlocked",  NB'(locked), NB'(1'b0));
        check("postrst_no_strobe", NB'(strobe_log.size() - log_mark), NB'(0));
        check("postrst_fd_zero",   NB'(frame_data), '0);
        send_word(SYNC, 1);
        send_word(32'h0102_0300, 1);
        for (int i = 0; i < NR; i++) send_word(32'h6000_0000 + 32'(i), 1);
        @(negedge clk);
        write_valid = 1'b0;
        check("relock_strobe43", frame_strobe, onehot(43));
        check_frame("frame_c2f3", 32'h6000_0000, -1);
        @(negedge clk);
        check("relock_strobe_gone", frame_strobe, '0);
        check("relock_locked", NB'(locked), NB'(1'b1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
